// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage types, the NOP encoding and the FSM states.
package fetch_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} state_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{instr: INSTR_NOP, pc: 32'h0, fault: 1'b0};

  function automatic fetch_entry_t fault_entry(input logic [31:0] pc);
    return '{instr: INSTR_NOP, pc: pc, fault: 1'b1};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetch entries with registered head and flush.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output logic         valid,
  output fetch_entry_t head
);

  fetch_entry_t s0, s1;
  logic do_pop, do_push;

  assign do_pop  = pop && count != 2'd0;
  assign do_push = push && (count != 2'd2 || do_pop);
  assign valid   = count != 2'd0;
  assign head    = s0;

  // s0 is always the oldest entry, so the head needs no read mux
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      s0    <= EMPTY_ENTRY;
      s1    <= EMPTY_ENTRY;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
      if (do_push && (count == 2'd0 || (count == 2'd1 && do_pop)))
        s0 <= din;
      else if (do_pop && count == 2'd2)
        s0 <= s1;
      if (do_push && (count == 2'd2 || (count == 2'd1 && !do_pop)))
        s1 <= din;
    end
  end

endmodule

// File: rtl/fetch.sv
// fetch: PC owner issuing word reads to imem and queueing {instr, pc, fault} for decode.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  input  logic        i_imem_err,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_fault,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  state_t       state;
  logic [31:0]  pc;
  logic [1:0]   count, count_after;
  logic         ack, push, pop;
  fetch_entry_t din, head;

  assign ack  = o_imem_req && i_imem_ack;
  assign pop  = o_valid && i_ready;
  assign push = !i_redirect && ((state == REQ && ack) ||
                                (state == IDLE && pc[1:0] != 2'b00 && count != 2'd2));
  assign din  = (state == REQ && !i_imem_err) ? '{instr: i_imem_data, pc: pc, fault: 1'b0}
                                              : fault_entry(pc);
  // occupancy once this cycle's push/pop land; a new request needs it below 2
  assign count_after = count + {1'b0, push} - {1'b0, pop};

  assign o_instr = head.instr;
  assign o_pc    = head.pc;
  assign o_fault = head.fault;

  fetch_buffer u_buf (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .flush (i_redirect),
    .din   (din),
    .count (count),
    .valid (o_valid),
    .head  (head)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      o_imem_req  <= 1'b0;
      o_imem_addr <= RESET_PC;
    end else if (i_redirect) begin
      pc <= i_redirect_pc;
      // a request still in flight must complete on the bus before we reissue
      if (o_imem_req && !i_imem_ack) begin
        state <= DROP;
      end else begin
        state      <= IDLE;
        o_imem_req <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: if (count != 2'd2) begin
          if (pc[1:0] == 2'b00) begin
            o_imem_req  <= 1'b1;
            o_imem_addr <= pc;
            state       <= REQ;
          end else begin
            state <= HALT;
          end
        end
        REQ: if (ack) begin
          if (i_imem_err) begin
            o_imem_req <= 1'b0;
            state      <= HALT;
          end else begin
            pc <= pc + 32'd4;
            if (count_after != 2'd2) begin
              o_imem_addr <= pc + 32'd4;
            end else begin
              o_imem_req <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        DROP: if (ack) begin
          o_imem_req <= 1'b0;
          state      <= IDLE;
        end
        HALT: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed scenarios plus a per-cycle stream model of the fetch stage.
module tb_fetch;
  import fetch_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_data = 32'h0;
  logic        i_imem_err = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_fault;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;

  int checks = 0;
  int passed = 0;

  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h20;
  int          wait_cnt = 0;

  fetch #(.RESET_PC(32'h0)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_data   (i_imem_data),
    .i_imem_err    (i_imem_err),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .o_fault       (o_fault),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_req(input logic [31:0] a, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      tick(1);
      ok = o_imem_req && o_imem_addr == a;
    end
  endtask

  task automatic wait_valid(input logic need_fault, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      tick(1);
      ok = o_valid && (!need_fault || o_fault);
    end
  endtask

  task automatic do_reset(input logic rdy);
    i_rst = 1'b1;
    i_redirect = 1'b0;
    i_ready = rdy;
    tick(2);
    i_rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    i_redirect = 1'b1;
    i_redirect_pc = target;
    tick(1);
    i_redirect = 1'b0;
  endtask

  // memory: acks every cycle, except stall_addr which waits 3 extra cycles
  initial forever begin
    @(posedge i_clk);
    #1;
    if (!o_imem_req || i_imem_ack) wait_cnt = 0;
    else wait_cnt++;
    i_imem_ack  = o_imem_req && (o_imem_addr != stall_addr || wait_cnt >= 3);
    i_imem_data = i_imem_ack ? mem(o_imem_addr) : 32'hDEAD_BEEF;
    i_imem_err  = i_imem_ack && err_en && o_imem_addr == err_addr;
  end

  // stream model: accepted entries follow exp_pc in steps of 4 from reset/redirect
  logic [31:0] exp_pc = 32'h0;
  logic        halted = 1'b0;
  logic        exp_fault;
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  initial forever begin
    @(negedge i_clk);
    if (i_rst) begin
      exp_pc = 32'h0;
      halted = 1'b0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (prev_req && !prev_ack) begin
        check("req_hold", o_imem_req, 1);
        check("addr_hold", o_imem_addr, prev_addr);
      end
      if (o_imem_req) check("req_aligned", o_imem_addr[1:0], 0);
      if (halted) begin
        check("halt_no_req", o_imem_req, 0);
        check("halt_no_valid", o_valid, 0);
      end
      if (o_valid && i_ready && !i_redirect) begin
        exp_fault = exp_pc[1:0] != 2'b00 || (err_en && exp_pc == err_addr);
        check("entry_pc", o_pc, exp_pc);
        check("entry_fault", o_fault, exp_fault);
        check("entry_instr", o_instr, exp_fault ? INSTR_NOP : mem(exp_pc));
        halted = exp_fault;
        exp_pc = exp_pc + 32'd4;
      end
      if (i_redirect) begin
        exp_pc = i_redirect_pc;
        halted = 1'b0;
      end
      prev_req  = o_imem_req;
      prev_ack  = i_imem_ack;
      prev_addr = o_imem_addr;
    end
  end

  initial begin
    logic ok;
    // reset values and first-fetch latency
    tick(2);
    check("rst_valid", o_valid, 0);
    check("rst_req", o_imem_req, 0);
    check("rst_fault", o_fault, 0);
    check("rst_instr", o_instr, 32'h0000_0013);
    check("rst_pc", o_pc, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_no_req", o_imem_req, 0);
    @(negedge i_clk);
    check("first_req", o_imem_req, 1);
    check("first_addr", o_imem_addr, 32'h0);
    check("first_not_valid", o_valid, 0);
    @(negedge i_clk);
    check("lat_valid", o_valid, 1);
    check("lat_pc0", o_pc, 32'h0);
    check("second_addr", o_imem_addr, 32'h4);
    @(negedge i_clk);
    check("stream_pc4", o_pc, 32'h4);
    @(negedge i_clk);
    check("stream_pc8", o_pc, 32'h8);

    // decode stalled: FIFO fills with 0 and 4, bus goes quiet
    do_reset(1'b0);
    tick(10);
    check("full_req_low", o_imem_req, 0);
    check("full_valid", o_valid, 1);
    check("full_head_pc", o_pc, 32'h0);
    check("full_addr_hold", o_imem_addr, 32'h4);
    i_ready = 1'b1;
    tick(1);
    check("drain_pc4", o_pc, 32'h4);
    tick(6);

    // redirect while the request to 0x8 is stalled on the bus
    stall_addr = 32'h8;
    do_reset(1'b1);
    wait_req(32'h8, ok);
    check("wait_req_8", ok, 1);
    redirect(32'h100);
    check("drop_valid", o_valid, 0);
    check("drop_req", o_imem_req, 1);
    check("drop_addr", o_imem_addr, 32'h8);
    wait_req(32'h100, ok);
    check("wait_req_100", ok, 1);
    stall_addr = 32'hFFFF_FFFF;
    wait_valid(1'b0, ok);
    check("wait_valid_100", ok, 1);
    check("redir_pc_100", o_pc, 32'h100);
    tick(4);

    // redirect coinciding with the ack of 0xC
    do_reset(1'b1);
    wait_req(32'hC, ok);
    check("wait_req_c", ok, 1);
    redirect(32'h200);
    check("same_ack_valid", o_valid, 0);
    check("same_ack_req", o_imem_req, 0);
    wait_valid(1'b0, ok);
    check("wait_valid_200", ok, 1);
    check("redir_pc_200", o_pc, 32'h200);
    tick(4);

    // bus error at 0x20 halts fetch until redirect
    err_en = 1'b1;
    do_reset(1'b1);
    wait_valid(1'b1, ok);
    check("wait_fault_20", ok, 1);
    check("err_pc", o_pc, 32'h20);
    check("err_instr", o_instr, 32'h0000_0013);
    tick(5);
    check("halt_req", o_imem_req, 0);
    check("halt_valid", o_valid, 0);
    redirect(32'h40);
    wait_valid(1'b0, ok);
    check("wait_valid_40", ok, 1);
    check("resume_pc", o_pc, 32'h40);
    check("resume_fault", o_fault, 0);
    tick(4);

    // misaligned redirect target becomes a fault without touching the bus
    redirect(32'h102);
    wait_valid(1'b0, ok);
    check("wait_valid_102", ok, 1);
    check("mis_pc", o_pc, 32'h102);
    check("mis_fault", o_fault, 1);
    check("mis_instr", o_instr, 32'h0000_0013);
    tick(3);
    check("mis_no_req", o_imem_req, 0);
    err_en = 1'b0;

    // asynchronous reset in the middle of a stalled request
    stall_addr = 32'h8;
    do_reset(1'b1);
    wait_req(32'h8, ok);
    check("wait_req_8b", ok, 1);
    check("pre_rst_valid", o_valid, 1);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_req", o_imem_req, 0);
    check("async_valid", o_valid, 0);
    check("async_pc", o_pc, 32'h0);
    tick(1);
    stall_addr = 32'hFFFF_FFFF;
    i_rst = 1'b0;
    wait_valid(1'b0, ok);
    check("post_rst_valid", ok, 1);
    check("post_rst_pc", o_pc, 32'h0);
    tick(5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
